// File: rtl/uart_pkg.sv
// Shared timing defaults, divisor helper and the bit-level state encoding used
// by both the transmit and receive paths of uart_core.
package uart_pkg;

    localparam int CLK_FREQ_DEF = 50000000;
    localparam int BAUD_DEF     = 115200;
    localparam int FRAME_BITS   = 10;
    localparam int DATA_BITS    = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    function automatic int calc_divisor(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_rx_unit.sv
// 8N1 receiver: two-flop input synchronizer, half-bit start qualification and
// mid-bit sampling. A framing error keeps the frame busy until the line idles.
module uart_rx_unit
    import uart_pkg::*;
#(
    parameter int DIVISOR = 434
) (
    input  logic       sys_clk_i,
    input  logic       sys_rst_i,
    input  logic       rd_en,
    input  logic       rx_line,
    output logic [7:0] rx_data,
    output logic       rx_busy,
    output logic       rx_done
);

    localparam int CNT_W = $clog2(DIVISOR);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(DIVISOR - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(DIVISOR / 2 - 1);

    logic              rx_meta_r;
    logic              rx_sync_r;
    uart_state_e       rx_state_r, rx_state_s;
    logic [CNT_W-1:0]  rx_cnt_r, rx_cnt_s;
    logic [2:0]        rx_bit_r, rx_bit_s;
    logic [7:0]        rx_shift_r, rx_shift_s;
    logic              rx_ferr_r, rx_ferr_s;
    logic [7:0]        rx_data_r, rx_data_s;
    logic              rx_busy_r, rx_busy_s;
    logic              rx_done_r, rx_done_s;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
        end else begin
            rx_meta_r <= rx_line;
            rx_sync_r <= rx_meta_r;
        end
    end

    // Receive FSM next-state and output logic.
    always_comb begin
        rx_state_s = rx_state_r;
        rx_cnt_s   = rx_cnt_r;
        rx_bit_s   = rx_bit_r;
        rx_shift_s = rx_shift_r;
        rx_ferr_s  = rx_ferr_r;
        rx_data_s  = rx_data_r;
        rx_busy_s  = rx_busy_r;
        rx_done_s  = 1'b0;
        case (rx_state_r)
            ST_IDLE: begin
                rx_busy_s = 1'b0;
                rx_ferr_s = 1'b0;
                if (rd_en && !rx_sync_r) begin
                    rx_state_s = ST_START;
                    rx_cnt_s   = '0;
                    rx_busy_s  = 1'b1;
                end else begin
                    rx_state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (rx_cnt_r == HALF_LAST) begin
                    rx_cnt_s = '0;
                    if (!rx_sync_r) begin
                        rx_state_s = ST_DATA;
                        rx_bit_s   = 3'd0;
                    end else begin
                        rx_state_s = ST_IDLE;
                        rx_busy_s  = 1'b0;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r + 1'b1;
                end
            end
            ST_DATA: begin
                if (rx_cnt_r == BIT_LAST) begin
                    rx_cnt_s   = '0;
                    rx_shift_s = {rx_sync_r, rx_shift_r[7:1]};
                    if (rx_bit_r == 3'd7) begin
                        rx_state_s = ST_STOP;
                    end else begin
                        rx_bit_s = rx_bit_r + 3'd1;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r + 1'b1;
                end
            end
            ST_STOP: begin
                // After a bad stop bit, hold here until the line idles high.
                if (rx_ferr_r) begin
                    if (rx_sync_r) begin
                        rx_state_s = ST_IDLE;
                        rx_busy_s  = 1'b0;
                        rx_ferr_s  = 1'b0;
                    end else begin
                        rx_state_s = ST_STOP;
                    end
                end else if (rx_cnt_r == BIT_LAST) begin
                    rx_cnt_s = '0;
                    if (rx_sync_r) begin
                        rx_data_s  = rx_shift_r;
                        rx_done_s  = 1'b1;
                        rx_busy_s  = 1'b0;
                        rx_state_s = ST_IDLE;
                    end else begin
                        rx_ferr_s = 1'b1;
                    end
                end else begin
                    rx_cnt_s = rx_cnt_r + 1'b1;
                end
            end
            default: begin
                rx_state_s = ST_IDLE;
                rx_cnt_s   = '0;
                rx_busy_s  = 1'b0;
                rx_ferr_s  = 1'b0;
            end
        endcase
    end

    // Receive FSM state and output registers.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            rx_state_r <= ST_IDLE;
            rx_cnt_r   <= '0;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'h00;
            rx_ferr_r  <= 1'b0;
            rx_data_r  <= 8'h00;
            rx_busy_r  <= 1'b0;
            rx_done_r  <= 1'b0;
        end else begin
            rx_state_r <= rx_state_s;
            rx_cnt_r   <= rx_cnt_s;
            rx_bit_r   <= rx_bit_s;
            rx_shift_r <= rx_shift_s;
            rx_ferr_r  <= rx_ferr_s;
            rx_data_r  <= rx_data_s;
            rx_busy_r  <= rx_busy_s;
            rx_done_r  <= rx_done_s;
        end
    end

    assign rx_data = rx_data_r;
    assign rx_busy = rx_busy_r;
    assign rx_done = rx_done_r;

endmodule

// File: rtl/uart_core.sv
// Full-duplex 8N1 UART. The transmitter lives here; the receiver is the
// uart_rx_unit instance. Both run off sys_clk_i with a synchronous reset.
module uart_core
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = CLK_FREQ_DEF,
    parameter int BAUD     = BAUD_DEF
) (
    input  logic       sys_clk_i,
    input  logic       sys_rst_i,
    input  logic       uart_wr_i,
    input  logic [7:0] uart_dat_i,
    output logic       uart_busy,
    output logic       uart_tx,
    input  logic       uart_rd_i,
    input  logic       uart_rx,
    output logic [7:0] uart_dat_o,
    output logic       uart_rx_busy,
    output logic       done
);

    localparam int DIVISOR = calc_divisor(CLK_FREQ, BAUD);
    localparam int CNT_W   = $clog2(DIVISOR);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(DIVISOR - 1);

    uart_state_e       tx_state_r, tx_state_s;
    logic [CNT_W-1:0]  tx_cnt_r, tx_cnt_s;
    logic [2:0]        tx_bit_r, tx_bit_s;
    logic [7:0]        tx_shift_r, tx_shift_s;
    logic              tx_line_r, tx_line_s;
    logic              tx_busy_r, tx_busy_s;

    // Transmit FSM next-state logic; the line value is registered with the state.
    always_comb begin
        tx_state_s = tx_state_r;
        tx_cnt_s   = tx_cnt_r;
        tx_bit_s   = tx_bit_r;
        tx_shift_s = tx_shift_r;
        tx_line_s  = tx_line_r;
        tx_busy_s  = tx_busy_r;
        case (tx_state_r)
            ST_IDLE: begin
                tx_line_s = 1'b1;
                tx_busy_s = 1'b0;
                if (uart_wr_i) begin
                    tx_state_s = ST_START;
                    tx_shift_s = uart_dat_i;
                    tx_cnt_s   = '0;
                    tx_line_s  = 1'b0;
                    tx_busy_s  = 1'b1;
                end else begin
                    tx_state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (tx_cnt_r == BIT_LAST) begin
                    tx_state_s = ST_DATA;
                    tx_cnt_s   = '0;
                    tx_bit_s   = 3'd0;
                    tx_line_s  = tx_shift_r[0];
                end else begin
                    tx_cnt_s = tx_cnt_r + 1'b1;
                end
            end
            ST_DATA: begin
                if (tx_cnt_r == BIT_LAST) begin
                    tx_cnt_s = '0;
                    if (tx_bit_r == 3'd7) begin
                        tx_state_s = ST_STOP;
                        tx_line_s  = 1'b1;
                    end else begin
                        tx_bit_s   = tx_bit_r + 3'd1;
                        tx_shift_s = {1'b0, tx_shift_r[7:1]};
                        tx_line_s  = tx_shift_r[1];
                    end
                end else begin
                    tx_cnt_s = tx_cnt_r + 1'b1;
                end
            end
            ST_STOP: begin
                if (tx_cnt_r == BIT_LAST) begin
                    tx_state_s = ST_IDLE;
                    tx_cnt_s   = '0;
                    tx_busy_s  = 1'b0;
                    tx_line_s  = 1'b1;
                end else begin
                    tx_cnt_s = tx_cnt_r + 1'b1;
                end
            end
            default: begin
                tx_state_s = ST_IDLE;
                tx_cnt_s   = '0;
                tx_line_s  = 1'b1;
                tx_busy_s  = 1'b0;
            end
        endcase
    end

    // Transmit FSM state and output registers.
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            tx_state_r <= ST_IDLE;
            tx_cnt_r   <= '0;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'h00;
            tx_line_r  <= 1'b1;
            tx_busy_r  <= 1'b0;
        end else begin
            tx_state_r <= tx_state_s;
            tx_cnt_r   <= tx_cnt_s;
            tx_bit_r   <= tx_bit_s;
            tx_shift_r <= tx_shift_s;
            tx_line_r  <= tx_line_s;
            tx_busy_r  <= tx_busy_s;
        end
    end

    assign uart_tx   = tx_line_r;
    assign uart_busy = tx_busy_r;

    uart_rx_unit #(
        .DIVISOR (DIVISOR)
    ) u_rx (
        .sys_clk_i (sys_clk_i),
        .sys_rst_i (sys_rst_i),
        .rd_en     (uart_rd_i),
        .rx_line   (uart_rx),
        .rx_data   (uart_dat_o),
        .rx_busy   (uart_rx_busy),
        .rx_done   (done)
    );

endmodule

// File: tb/tb_uart_core.sv
// Scoreboard bench for uart_core: stimulus pushes expected bytes, independent
// monitors decode uart_tx and watch done, popping and comparing.
module tb_uart_core;

    localparam int DIV   = 434;
    localparam int HALF  = 217;
    localparam int FRAME = 4340;

    logic       sys_clk_i = 1'b0;
    logic       sys_rst_i = 1'b1;
    logic       uart_wr_i = 1'b0;
    logic [7:0] uart_dat_i = 8'h00;
    logic       uart_rd_i = 1'b0;
    logic       uart_rx = 1'b1;
    logic       uart_busy;
    logic       uart_tx;
    logic [7:0] uart_dat_o;
    logic       uart_rx_busy;
    logic       done;

    int n_checks = 0;
    int n_pass = 0;
    int rst_count = 0;
    bit mon_go = 1'b0;
    logic [7:0] tx_q[$];
    logic [7:0] rx_q[$];
    int busy_cnt = 0;
    int busy_snap = 0;

    uart_core dut (
        .sys_clk_i    (sys_clk_i),
        .sys_rst_i    (sys_rst_i),
        .uart_wr_i    (uart_wr_i),
        .uart_dat_i   (uart_dat_i),
        .uart_busy    (uart_busy),
        .uart_tx      (uart_tx),
        .uart_rd_i    (uart_rd_i),
        .uart_rx      (uart_rx),
        .uart_dat_o   (uart_dat_o),
        .uart_rx_busy (uart_rx_busy),
        .done         (done)
    );

    always #10 sys_clk_i = ~sys_clk_i;

    always @(posedge sys_clk_i) if (sys_rst_i) rst_count++;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tx_write(input logic [7:0] b, input int hold);
        int t = 0;
        while (uart_busy && t < 6000) begin
            @(negedge sys_clk_i);
            t++;
        end
        chk("tx_idle_before_write", int'(uart_busy), 0);
        uart_dat_i = b;
        uart_wr_i  = 1'b1;
        tx_q.push_back(b);
        repeat (hold) @(negedge sys_clk_i);
        uart_wr_i = 1'b0;
    endtask

    task automatic rx_frame(input logic [7:0] b, input logic stop_bit, input logic exp_busy);
        uart_rx = 1'b0;
        repeat (DIV) @(negedge sys_clk_i);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (DIV) @(negedge sys_clk_i);
            if (i == 4) chk("rx_busy_midframe", int'(uart_rx_busy), int'(exp_busy));
        end
        uart_rx = stop_bit;
        repeat (DIV) @(negedge sys_clk_i);
        uart_rx = 1'b1;
    endtask

    task automatic wait_tx_idle();
        int t = 0;
        while (uart_busy && t < 6000) begin
            @(negedge sys_clk_i);
            t++;
        end
        chk("tx_idle_timeout", int'(uart_busy), 0);
    endtask

    // TX monitor: decode each frame at mid-bit and compare against the queue.
    initial begin
        logic [7:0] b;
        logic s0, s9;
        int snap;
        wait (mon_go);
        forever begin
            @(negedge sys_clk_i);
            if (uart_tx == 1'b0) begin
                snap = rst_count;
                repeat (HALF) @(negedge sys_clk_i);
                s0 = uart_tx;
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV) @(negedge sys_clk_i);
                    b[i] = uart_tx;
                end
                repeat (DIV) @(negedge sys_clk_i);
                s9 = uart_tx;
                if (snap == rst_count) begin
                    chk("tx_start_bit", int'(s0), 0);
                    chk("tx_stop_bit", int'(s9), 1);
                    chk("tx_frame_expected", (tx_q.size() > 0) ? 1 : 0, 1);
                    if (tx_q.size() > 0) chk("tx_byte", int'(b), int'(tx_q.pop_front()));
                end
            end
        end
    end

    // Busy-length monitor: each uninterrupted busy window is one frame long.
    always @(negedge sys_clk_i) begin
        if (mon_go) begin
            if (uart_busy) begin
                if (busy_cnt == 0) busy_snap = rst_count;
                busy_cnt++;
            end else if (busy_cnt != 0) begin
                if (busy_snap == rst_count) chk("tx_busy_length", busy_cnt, FRAME);
                busy_cnt = 0;
            end
        end
    end

    // RX monitor: every done pulse must match the next expected byte.
    always @(negedge sys_clk_i) begin
        if (mon_go && done) begin
            chk("rx_done_expected", (rx_q.size() > 0) ? 1 : 0, 1);
            if (rx_q.size() > 0) chk("rx_byte", int'(uart_dat_o), int'(rx_q.pop_front()));
        end
    end

    initial begin
        repeat (10) @(negedge sys_clk_i);
        chk("rst_tx", int'(uart_tx), 1);
        chk("rst_busy", int'(uart_busy), 0);
        chk("rst_rx_busy", int'(uart_rx_busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_dat_o", int'(uart_dat_o), 0);
        sys_rst_i = 1'b0;
        repeat (5) @(negedge sys_clk_i);
        mon_go = 1'b1;

        // Held write sends exactly one frame.
        tx_write(8'h1B, 10);
        chk("tx_busy_after_accept", int'(uart_busy), 1);
        repeat (6300) @(negedge sys_clk_i);

        // Second TX frame concurrent with an RX frame.
        fork
            tx_write(8'h1E, 10);
            begin
                uart_rd_i = 1'b1;
                rx_q.push_back(8'h75);
                rx_frame(8'h75, 1'b1, 1'b1);
            end
        join
        repeat (20) @(negedge sys_clk_i);
        chk("rx_busy_after_frame", int'(uart_rx_busy), 0);
        chk("rx_dat_0x75", int'(uart_dat_o), 8'h75);
        wait_tx_idle();

        // 50-cycle glitch is detected then rejected at the half-bit check.
        uart_rx = 1'b0;
        repeat (30) @(negedge sys_clk_i);
        chk("rx_glitch_detect", int'(uart_rx_busy), 1);
        repeat (20) @(negedge sys_clk_i);
        uart_rx = 1'b1;
        repeat (300) @(negedge sys_clk_i);
        chk("rx_glitch_reject", int'(uart_rx_busy), 0);

        // Framing error: stop bit low, data register untouched.
        rx_frame(8'hA5, 1'b0, 1'b1);
        repeat (10) @(negedge sys_clk_i);
        chk("rx_ferr_busy_clear", int'(uart_rx_busy), 0);
        chk("rx_ferr_dat_hold", int'(uart_dat_o), 8'h75);

        // Receive disabled: frame ignored.
        uart_rd_i = 1'b0;
        rx_frame(8'h3C, 1'b1, 1'b0);
        repeat (20) @(negedge sys_clk_i);
        chk("rx_disabled_busy", int'(uart_rx_busy), 0);
        chk("rx_disabled_dat", int'(uart_dat_o), 8'h75);

        // Reset in the middle of both a TX and an RX frame.
        uart_rd_i  = 1'b1;
        uart_dat_i = 8'h55;
        uart_wr_i  = 1'b1;
        @(negedge sys_clk_i);
        uart_wr_i = 1'b0;
        uart_rx   = 1'b0;
        repeat (1000) @(negedge sys_clk_i);
        chk("mid_tx_busy", int'(uart_busy), 1);
        chk("mid_rx_busy", int'(uart_rx_busy), 1);
        sys_rst_i = 1'b1;
        uart_rx   = 1'b1;
        @(negedge sys_clk_i);
        chk("midrst_tx", int'(uart_tx), 1);
        chk("midrst_busy", int'(uart_busy), 0);
        chk("midrst_rx_busy", int'(uart_rx_busy), 0);
        chk("midrst_dat_o", int'(uart_dat_o), 0);
        sys_rst_i = 1'b0;
        repeat (5000) @(negedge sys_clk_i);

        chk("tx_queue_drained", tx_q.size(), 0);
        chk("rx_queue_drained", rx_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_core.md
Name: uart_core

Overview:
- Full-duplex 8N1 UART: one transmitter and one receiver sharing one system clock.
- Sits between on-chip logic (parallel byte interface) and the serial pins.
- Default timing is 50 MHz system clock at 115200 baud, i.e. 434 clocks per bit.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD, 115200, serial bit rate.
- DIVISOR, CLK_FREQ/BAUD (434, truncated), clocks per bit. Derived; not overridden independently.

Ports:
- sys_clk_i  in  1  system clock; all logic on rising edge.
- sys_rst_i  in  1  synchronous, active-high reset.
- uart_wr_i  in  1  transmit request; accepted when sampled high while uart_busy=0.
- uart_dat_i  in  8  byte to transmit; captured in the acceptance cycle.
- uart_busy  out  1  transmitter busy.
- uart_tx  out  1  serial TX line; idles high.
- uart_rd_i  in  1  receive enable (level); start bits are detected only while high.
- uart_rx  in  1  serial RX line, asynchronous.
- uart_dat_o  out  8  last received byte; holds until the next valid byte.
- uart_rx_busy  out  1  a receive frame is in progress.
- done  out  1  one-cycle pulse when a valid byte lands in uart_dat_o.

Behaviour:
- One clock (sys_clk_i). Reset is synchronous and active-high (sys_rst_i); it overrides everything, including mid-frame.
- Reset values: uart_tx=1, uart_busy=0, uart_dat_o=0, uart_rx_busy=0, done=0. All counters and FSMs return to IDLE.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit is DIVISOR clocks. No parity.

TX FSM (IDLE, START, DATA, STOP):
- IDLE: uart_tx=1. When uart_wr_i=1 is sampled, latch uart_dat_i and go to START.
- uart_busy is 1 from the cycle after acceptance until the last stop-bit clock. It returns to 0 the following cycle.
- uart_tx drives 0 for DIVISOR clocks, then bits d0..d7 for DIVISOR clocks each, then 1 for DIVISOR clocks. Total frame is 10*DIVISOR clocks.
- uart_wr_i is level-sampled and only acted on in IDLE. Writes while busy are ignored; there is no queue.
- If uart_wr_i is still high when the frame ends, a new frame starts. Callers deassert uart_wr_i before the frame ends.

RX FSM (IDLE, START, DATA, STOP):
- uart_rx passes through a 2-flop synchronizer before any use.
- IDLE: when uart_rd_i=1 and the synchronized line is 0, go to START and set uart_rx_busy=1.
- START: wait DIVISOR/2 clocks (217), then resample. If the line is still 0, go to DATA. If it is 1, treat it as a glitch: return to IDLE and clear uart_rx_busy.
- DATA: sample every DIVISOR clocks (mid-bit). Shift bits in LSB first, 8 samples total.
- STOP: sample one DIVISOR later. If the line is 1: load uart_dat_o, pulse done for one cycle, clear uart_rx_busy (same cycle), return to IDLE.
- Framing error (stop bit = 0): uart_dat_o is unchanged, no done pulse. Wait for the line to return to 1, then go to IDLE.
- Dropping uart_rd_i mid-frame does not abort the frame. It only blocks new start detection.
- TX and RX are independent and may run simultaneously.

Decomposition:
- Package uart_pkg: CLK_FREQ/BAUD defaults, DIVISOR computation, frame length constant (10), FSM state enum shared by TX and RX.
- One natural sub-module: uart_rx_unit (synchronizer, half-bit start check, sampling FSM).
- TX stays inline in uart_core.

Test Plan:
- Reset: hold sys_rst_i high for 10 cycles → uart_tx=1, uart_busy=0, uart_rx_busy=0, done=0, uart_dat_o=0.
- TX 0x1B: uart_wr_i=1 with uart_dat_i=27 for 10 cycles → uart_busy high for 4340 cycles. uart_tx shows 0,1,1,0,1,1,0,0,0,1, each 434 cycles. Only one frame is sent.
- TX back-to-back: second write of 0x1E about 6310 cycles later → second frame 0,0,1,1,1,1,0,0,0,1. No corruption of, or overlap with, the first frame.
- RX 0x75: uart_rd_i=1, then drive uart_rx = 0 (start), bits 1,0,1,0,1,1,1,0, then 1 (stop), each 434 cycles → done pulses once at mid-stop-bit, uart_dat_o=0x75, uart_rx_busy covers the frame.
- RX glitch and framing error:
  - a 50-cycle low pulse on uart_rx → no uart_rx_busy after the check, no done;
  - a frame with stop bit 0 → no done, uart_dat_o keeps 0x75.
- Receive enable and mid-frame reset:
  - a frame with uart_rd_i=0 → ignored;
  - sys_rst_i asserted mid-TX and mid-RX → next cycle uart_tx=1, both busy flags 0.
